fu_pipe: RTL and testbench
==========================

Name: fu_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle execution functional unit; sits between the reservation-station issue port and the common data bus (CDB).
- Computes ALU results and load/store effective addresses. Carries PC and destination tag alongside each result.
- Replaces high-Z/X operand detection with explicit valid/ready handshakes on both sides.
- Supports a configurable pipeline depth, CDB back-pressure and a squash (flush) input.

Parameters:
- DATA_W, 16, operand/result/PC width
- TAG_W, 3, destination tag width
- LAT, 2, pipeline stages from issue to result register (legal 1..4)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  squash all in-flight ops (branch mispredict)
- in_valid  in  1  issue slot holds a ready operation
- in_ready  out  1  unit accepts an op this cycle
- opcode  in  4  operation select
- a, b, imm  in  DATA_W each  source operands and immediate
- pc_in  in  DATA_W  PC of issued instruction
- dest_tag_in  in  TAG_W  ROB/RS destination tag
- out_valid  out  1  result valid on CDB (broadcast)
- out_ready  in  1  CDB grant; result consumed when out_valid && out_ready
- sum  out  DATA_W  ALU result or effective address
- pc_out  out  DATA_W  PC travelling with result
- dest_tag_out  out  TAG_W  tag travelling with result
- st_value  out  DATA_W  store data (operand a) for STORE, else 0
- type_value  out  2  00 ALU, 01 STORE, 10 LOAD

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all stage valid bits cleared; out_valid=0
  - sum, pc_out, dest_tag_out, st_value, type_value all 0
  - in_ready=1 in the cycle after reset deasserts
  - reset mid-operation discards every in-flight op
- Opcode map (results mod 2^DATA_W; carry dropped):
  - 0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b; 0110 a^b; 0111 a+imm
  - 0100 LOAD: b+imm, type_value=10
  - 0101 STORE: b+imm, st_value=a, type_value=01
  - any other opcode: a+b, type_value=00
- Computation and capture:
  - computed combinationally in stage 1, captured together with pc, tag, st_value and type
  - stages 2..LAT are pure delay registers
  - the last stage drives the outputs directly (registered outputs)
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+LAT-1 (LAT=1 → visible the cycle after acceptance), provided there is no stall.
- Pipeline advance: stage k advances when stage k+1 is empty or stage k+1 advances. The last stage advances when !out_valid || out_ready.
- in_ready = stage 1 empty or stage 1 advances (combinational from out_ready through the chain). Acceptance occurs when in_valid && in_ready.
- Stall: when out_valid=1 and out_ready=0:
  - all outputs hold stable
  - upstream bubbles still collapse
  - in_ready falls only when every stage is full
- Throughput: one op per cycle with out_ready held at 1.
- While out_valid=0, data outputs keep their last value. Consumers must qualify on out_valid; outputs never go high-Z.
- flush=1:
  - clears all valid bits at the next edge and blocks acceptance that cycle (flush wins over in_valid)
  - out_valid=0 the following cycle
  - data registers need not clear
- Simultaneous consume and accept with a full pipeline: legal, no bubble inserted.

Optional Feature:
- FU_OVF_FLAG_EN defined:
  - adds output port ovf (1 bit), registered and pipelined with the result
  - ovf=1 on signed two's-complement overflow for opcodes 0000, 0001, 0111; 0 for all other opcodes
  - ovf resets to 0
- FU_OVF_FLAG_EN undefined: no ovf port and no overflow logic.

Test Plan:
- Reset hold → rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, all outputs 0; in_ready=1 after release.
- Basic ALU, LAT=2 → ADD a=0x0005 b=0x0003 pc=0x0010 tag=3 → two edges later: sum=0x0008, pc_out=0x0010, dest_tag_out=3, type_value=00, out_valid=1 for one cycle (out_ready=1).
- Wrap and memory ops:
  - ADD 0xFFFF+0x0002 → sum=0x0001
  - STORE a=0x00AA b=0x0100 imm=0x0004 → sum=0x0104, st_value=0x00AA, type_value=01
  - LOAD b=0x0200 imm=0xFFFF → sum=0x01FF, type_value=10
- Back-pressure:
  - issue 4 ops back-to-back with out_ready=0 → in_ready drops after LAT accepted; first result held stable
  - then raise out_ready → results retire in order, one per cycle, none lost or duplicated
- Flush mid-flight → flush=1 with 2 ops in flight and in_valid=1 → next cycle out_valid=0, the third op is not accepted, pipeline empty.
- FU_OVF_FLAG_EN → ADD 0x7FFF+0x0001 → sum=0x8000, ovf=1; SUB 0x0003-0x0001 → ovf=0.

Source files
------------

// File: rtl/fu_pipe.sv
// fu_pipe: pipelined execution unit (ALU ops + load/store effective address) between RS issue and CDB.
// Latency: LAT cycles from accept to registered result (op accepted at edge N is visible after edge N+LAT-1).
// Backpressure: valid/ready per stage; bubbles collapse under stall, in_ready drops only when all stages full.
//
// Ports:
//   clk, rst_n (sync, active-low), flush (squash in-flight ops, blocks acceptance that cycle)
//   in_valid/in_ready + opcode, a, b, imm, pc_in, dest_tag_in : issue side
//   out_valid/out_ready + sum, pc_out, dest_tag_out, st_value, type_value : CDB side
//   ovf : signed overflow flag, present only when FU_OVF_FLAG_EN is defined
// Optional feature macro: FU_OVF_FLAG_EN
// LAT must lie in 1..4.
module fu_pipe #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [TAG_W-1:0]  dest_tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] pc_out,
  output logic [TAG_W-1:0]  dest_tag_out,
  output logic [DATA_W-1:0] st_value,
  output logic [1:0]        type_value
`ifdef FU_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [1:0] TYPE_ALU   = 2'b00;
  localparam logic [1:0] TYPE_STORE = 2'b01;
  localparam logic [1:0] TYPE_LOAD  = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] st;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        typ;
`ifdef FU_OVF_FLAG_EN
    logic              ovf;
`endif
  } stage_t;

  stage_t           comp;
  stage_t           dat [LAT];
  logic [LAT-1:0]   vld;
  logic [LAT-1:0]   rdy;
  logic             accept;

  // Stage 1 combinational compute.
  always_comb begin
    comp     = '0;
    comp.pc  = pc_in;
    comp.tag = dest_tag_in;
    comp.typ = TYPE_ALU;
    case (opcode)
      4'b0000: comp.sum = a + b;
      4'b0001: comp.sum = a - b;
      4'b0010: comp.sum = a & b;
      4'b0011: comp.sum = a | b;
      4'b0110: comp.sum = a ^ b;
      4'b0111: comp.sum = a + imm;
      4'b0100: begin
        comp.sum = b + imm;
        comp.typ = TYPE_LOAD;
      end
      4'b0101: begin
        comp.sum = b + imm;
        comp.st  = a;
        comp.typ = TYPE_STORE;
      end
      default: comp.sum = a + b;
    endcase
`ifdef FU_OVF_FLAG_EN
    // Add overflows when operands share a sign the result lacks; subtract
    // overflows when operand signs differ and the result sign flips from a.
    case (opcode)
      4'b0000: comp.ovf = (a[DATA_W-1] == b[DATA_W-1])   && (comp.sum[DATA_W-1] != a[DATA_W-1]);
      4'b0001: comp.ovf = (a[DATA_W-1] != b[DATA_W-1])   && (comp.sum[DATA_W-1] != a[DATA_W-1]);
      4'b0111: comp.ovf = (a[DATA_W-1] == imm[DATA_W-1]) && (comp.sum[DATA_W-1] != a[DATA_W-1]);
      default: comp.ovf = 1'b0;
    endcase
`endif
  end

  // Stage k can take new data when any stage from k to the end is empty or
  // the CDB is consuming; written in closed form to avoid a chained vector.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < LAT; j++) begin
        if (!vld[j]) rdy[k] = 1'b1;
      end
    end
  end

  // Flush forces in_ready low so the issue side never sees a dropped handshake.
  assign in_ready = rdy[0] && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) dat[k] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= accept;
        if (accept) dat[0] <= comp;
      end
      for (int k = 1; k < LAT; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          // Data only moves with a valid op so idle outputs keep their last value.
          if (vld[k-1]) dat[k] <= dat[k-1];
        end
      end
    end
  end

  assign out_valid    = vld[LAT-1];
  assign sum          = dat[LAT-1].sum;
  assign pc_out       = dat[LAT-1].pc;
  assign dest_tag_out = dat[LAT-1].tag;
  assign st_value     = dat[LAT-1].st;
  assign type_value   = dat[LAT-1].typ;
`ifdef FU_OVF_FLAG_EN
  assign ovf          = dat[LAT-1].ovf;
`endif

endmodule

// File: tb/tb_fu_pipe.sv
// tb_fu_pipe: scoreboard bench for fu_pipe with directed, hand-computed vectors.
// Latency: exercises default LAT=2 timing, stall, flush and reset mid-flight.
// Backpressure: toggles out_ready to fill the pipeline and checks held outputs.
module tb_fu_pipe;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] a, b, imm, pc_in;
  logic [TAG_W-1:0]  dest_tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum, pc_out, st_value;
  logic [TAG_W-1:0]  dest_tag_out;
  logic [1:0]        type_value;
`ifdef FU_OVF_FLAG_EN
  logic              ovf;
`endif

  always #5 clk = ~clk;

  fu_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .imm(imm), .pc_in(pc_in), .dest_tag_in(dest_tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .pc_out(pc_out), .dest_tag_out(dest_tag_out),
    .st_value(st_value), .type_value(type_value)
`ifdef FU_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] st;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        typ;
    logic              ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Monitor: every cycle with out_valid the outputs must match the oldest
  // outstanding op (so held-stable under stall is checked too); pop on consume.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got sum=%h tag=%0d, required no output", sum, dest_tag_out);
      end else begin
        e_mon = sb[0];
        if (sum !== e_mon.sum || pc_out !== e_mon.pc || dest_tag_out !== e_mon.tag ||
            st_value !== e_mon.st || type_value !== e_mon.typ
`ifdef FU_OVF_FLAG_EN
            || ovf !== e_mon.ovf
`endif
           ) begin
          n_fail++;
          $display("FAIL result: got sum=%h pc=%h tag=%0d st=%h type=%b, required sum=%h pc=%h tag=%0d st=%h type=%b ovf=%b",
                   sum, pc_out, dest_tag_out, st_value, type_value,
                   e_mon.sum, e_mon.pc, e_mon.tag, e_mon.st, e_mon.typ, e_mon.ovf);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one op; returns 2 time units after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] iimm, input logic [15:0] ipc, input logic [2:0] itag,
                       input logic [15:0] esum, input logic [15:0] est, input logic [1:0] etyp,
                       input logic eovf);
    exp_t e;
    int t;
    in_valid = 1'b1; opcode = op; a = ia; b = ib; imm = iimm; pc_in = ipc; dest_tag_in = itag;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("issue_timeout", 32'd0, 32'd1);
    end else begin
      e.sum = esum; e.pc = ipc; e.st = est; e.tag = itag; e.typ = etyp; e.ovf = eovf;
      sb.push_back(e);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; opcode = 4'b0000; a = 16'h0005; b = 16'h0003; imm = 16'h0;
    pc_in = 16'h0010; dest_tag_in = 3'd3;

    // Reset held two cycles with in_valid asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_tag", dest_tag_out, 0);
    chk("rst_st_value", st_value, 0);
    chk("rst_type", type_value, 0);
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #2;

    // Basic ADD with latency check.
    issue(4'b0000, 16'h0005, 16'h0003, 16'h0000, 16'h0010, 3'd3, 16'h0008, 16'h0000, 2'b00, 1'b0);
    @(negedge clk); chk("lat_not_yet", out_valid, 0);
    @(negedge clk); chk("lat_valid", out_valid, 1);
    @(negedge clk); chk("lat_one_cycle", out_valid, 0);
    @(posedge clk); #2;

    // Back-to-back directed vectors, out_ready=1.
    issue(4'b0000, 16'hFFFF, 16'h0002, 16'h0000, 16'h0020, 3'd1, 16'h0001, 16'h0000, 2'b00, 1'b0);
    issue(4'b0101, 16'h00AA, 16'h0100, 16'h0004, 16'h0022, 3'd2, 16'h0104, 16'h00AA, 2'b01, 1'b0);
    issue(4'b0100, 16'h1234, 16'h0200, 16'hFFFF, 16'h0024, 3'd4, 16'h01FF, 16'h0000, 2'b10, 1'b0);
    issue(4'b0001, 16'h0003, 16'h0005, 16'h0000, 16'h0026, 3'd5, 16'hFFFE, 16'h0000, 2'b00, 1'b0);
    issue(4'b0010, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0028, 3'd6, 16'h3030, 16'h0000, 2'b00, 1'b0);
    issue(4'b0011, 16'hF0F0, 16'h0F01, 16'h0000, 16'h002A, 3'd7, 16'hFFF1, 16'h0000, 2'b00, 1'b0);
    issue(4'b0110, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h002C, 3'd0, 16'h5555, 16'h0000, 2'b00, 1'b0);
    issue(4'b0111, 16'h0010, 16'h1111, 16'hFFF0, 16'h002E, 3'd1, 16'h0000, 16'h0000, 2'b00, 1'b0);
    issue(4'b1000, 16'h0001, 16'h0002, 16'h0000, 16'h0030, 3'd2, 16'h0003, 16'h0000, 2'b00, 1'b0);
    issue(4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0032, 3'd3, 16'h8000, 16'h0000, 2'b00, 1'b1);
    issue(4'b0001, 16'h0003, 16'h0001, 16'h0000, 16'h0034, 3'd4, 16'h0002, 16'h0000, 2'b00, 1'b0);
    drain("drain_vectors");

    // Back-pressure: four ops with out_ready=0, release later.
    @(posedge clk); #2;
    out_ready = 1'b0;
    fork
      begin
        issue(4'b0000, 16'h0001, 16'h0001, 16'h0000, 16'h0100, 3'd1, 16'h0002, 16'h0000, 2'b00, 1'b0);
        issue(4'b0000, 16'h0002, 16'h0002, 16'h0000, 16'h0102, 3'd2, 16'h0004, 16'h0000, 2'b00, 1'b0);
        issue(4'b0000, 16'h0003, 16'h0003, 16'h0000, 16'h0104, 3'd3, 16'h0006, 16'h0000, 2'b00, 1'b0);
        issue(4'b0000, 16'h0004, 16'h0004, 16'h0000, 16'h0106, 3'd4, 16'h0008, 16'h0000, 2'b00, 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        chk("in_ready_stall", in_ready, 0);
        chk("accepted_before_stall", sb.size(), LAT);
        chk("out_valid_stall", out_valid, 1);
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Flush with two ops in flight and a third offered.
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(4'b0000, 16'h0010, 16'h0001, 16'h0000, 16'h0200, 3'd5, 16'h0011, 16'h0000, 2'b00, 1'b0);
    issue(4'b0000, 16'h0020, 16'h0001, 16'h0000, 16'h0202, 3'd6, 16'h0021, 16'h0000, 2'b00, 1'b0);
    flush = 1'b1; in_valid = 1'b1; opcode = 4'b0000; a = 16'h0030; b = 16'h0001;
    @(negedge clk);
    chk("in_ready_during_flush", in_ready, 0);
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_stays_empty", out_valid, 0);
    @(posedge clk); #2;
    issue(4'b0110, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0300, 3'd7, 16'h0FF0, 16'h0000, 2'b00, 1'b0);
    drain("drain_after_flush");

    // Reset mid-flight discards the op.
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(4'b0000, 16'h1000, 16'h0001, 16'h0000, 16'h0400, 3'd1, 16'h1001, 16'h0000, 2'b00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_stays_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
